// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Streams `len` consecutive words, starting at `base_addr`, out of a
//   single-port block memory (1-cycle registered read) onto a valid/ready
//   stream. Reads are credit-limited against a 4-entry skid FIFO, so
//   backpressure never drops data and m_data is always registered.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             request pulse, honoured only in IDLE
//   base_addr, len    transfer descriptor, latched on an accepted start
//   busy, done        busy = READ|DRAIN, done = one-cycle completion pulse
//   mem_en/we/addr    BRAM read port (we tied low)
//   mem_dout          BRAM read data, valid the cycle after mem_en
//   m_valid/ready/data output stream
module bram_stream_reader #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int LW    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LW-1:0]    len,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

    state_t           r_state, w_next;
    logic [AW-1:0]    r_addr;       // next address to issue
    logic [AW-1:0]    r_addr_hold;  // last issued address, shown while idle
    logic [LW-1:0]    r_remain;
    logic             r_inflight;   // a read was issued last cycle
    logic [WIDTH-1:0] r_fifo [4];
    logic [1:0]       r_wr_ptr, r_rd_ptr;
    logic [2:0]       r_count;

    logic             w_start_acc;
    logic             w_issue;
    logic             w_push, w_pop;
    logic [2:0]       w_credit;
    logic [AW-1:0]    w_addr_nxt;

    assign w_start_acc = (r_state == S_IDLE) && start;
    // Occupancy plus the word still coming out of the BRAM must stay below 3
    // before a new read goes out; this keeps the FIFO at or under 3 entries.
    assign w_credit    = r_count + {2'b00, r_inflight};
    assign w_issue     = (r_state == S_READ) && (r_remain != '0) && (w_credit < 3'd3);
    assign w_push      = r_inflight;
    assign w_pop       = (r_count != 3'd0) && m_ready;
    assign w_addr_nxt  = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);

    assign mem_en   = w_issue;
    assign mem_we   = 1'b0;
    assign mem_addr = w_issue ? r_addr : r_addr_hold;
    assign m_valid  = (r_count != 3'd0);
    assign m_data   = r_fifo[r_rd_ptr];
    assign busy     = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done     = (r_state == S_FIN);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len == '0) ? S_FIN : S_READ;
            S_READ:  if (w_issue && r_remain == LW'(1)) w_next = S_DRAIN;
            // Exit when nothing is in flight and the last beat is leaving
            // (or has left) so done lands the cycle after its handshake.
            S_DRAIN: if (!r_inflight && (r_count == 3'd0 || (r_count == 3'd1 && w_pop)))
                         w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_addr_hold <= '0;
            r_remain    <= '0;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
        end else begin
            if (w_start_acc) begin
                r_addr   <= base_addr;
                r_remain <= len;
            end else if (w_issue) begin
                r_addr      <= w_addr_nxt;
                r_addr_hold <= r_addr;
                r_remain    <= r_remain - LW'(1);
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_dout;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push && !w_pop) assert (r_count < 3'd4);
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;
    localparam int WIDTH = 128;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int LW    = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [LW-1:0]    len = '0;
    logic             busy, done, mem_en, mem_we, m_valid;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_dout = '0;
    logic             m_ready = 1'b1;
    logic [WIDTH-1:0] m_data;

    logic [WIDTH-1:0] tb_mem [DEPTH];

    int n_chk = 0;
    int n_err = 0;

    logic [WIDTH-1:0] q_beats [$];
    logic [AW-1:0]    q_addr  [$];
    int               n_done  = 0;
    logic [2:0]       max_cnt = '0;
    logic             p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
    logic [WIDTH-1:0] p_data  = '0;

    bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_dout <= tb_mem[mem_addr];

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: records handshakes, issued addresses, done pulses
    // and checks that a stalled beat holds.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) q_beats.push_back(m_data);
            if (mem_en) q_addr.push_back(mem_addr);
            if (done) n_done <= n_done + 1;
            if (dut.r_count > max_cnt) max_cnt <= dut.r_count;
            if (p_valid && !p_ready && !p_rst) begin
                chk("hold_valid", WIDTH'(m_valid), WIDTH'(1));
                chk("hold_data", m_data, p_data);
            end
        end
        p_valid <= m_valid;
        p_ready <= m_ready;
        p_data  <= m_data;
        p_rst   <= rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input int b, input int l);
        base_addr = AW'(b);
        len       = LW'(l);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // mode 0: m_ready held high, mode 1: m_ready high one cycle in three
    task automatic run_xfer(input int budget, input int mode);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            m_ready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
            if (done) begin ok = 1; break; end
            tick();
        end
        m_ready = 1'b1;
        chk("xfer_done", WIDTH'(ok), WIDTH'(1));
        if (ok) tick();
    endtask

    task automatic check_beats(input int b0, input int base, input int n);
        chk("beat_cnt", WIDTH'(q_beats.size() - b0), WIDTH'(n));
        for (int i = 0; i < n; i++)
            if (b0 + i < q_beats.size())
                chk("beat", q_beats[b0 + i], WIDTH'((base + i) % DEPTH));
    endtask

    initial begin
        int b0, a0, d0, b1, d1;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = WIDTH'(i);

        // reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",  WIDTH'(busy), '0);
        chk("rst_done",  WIDTH'(done), '0);
        chk("rst_en",    WIDTH'(mem_en), '0);
        chk("rst_we",    WIDTH'(mem_we), '0);
        chk("rst_addr",  WIDTH'(mem_addr), '0);
        chk("rst_valid", WIDTH'(m_valid), '0);
        chk("rst_data",  m_data, '0);

        // basic stream, cycle-exact
        b0 = q_beats.size(); d0 = n_done;
        start_xfer(16'h010, 4);
        for (int k = 1; k <= 7; k++) begin
            chk("bas_en",    WIDTH'(mem_en), WIDTH'(k <= 4));
            chk("bas_addr",  WIDTH'(mem_addr), WIDTH'(16'h010 + ((k <= 4) ? k : 4) - 1));
            chk("bas_valid", WIDTH'(m_valid), WIDTH'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("bas_data", m_data, WIDTH'(16'h010 + k - 3));
            chk("bas_done",  WIDTH'(done), WIDTH'(k == 7));
            chk("bas_busy",  WIDTH'(busy), WIDTH'(k <= 6));
            tick();
        end
        chk("bas_done_off", WIDTH'(done), '0);
        check_beats(b0, 16'h010, 4);
        chk("bas_ndone", WIDTH'(n_done - d0), WIDTH'(1));

        // backpressure
        b0 = q_beats.size(); d0 = n_done;
        start_xfer(16'h100, 8);
        run_xfer(200, 1);
        check_beats(b0, 16'h100, 8);
        chk("bp_ndone", WIDTH'(n_done - d0), WIDTH'(1));
        chk("bp_maxcnt_le3", WIDTH'(max_cnt <= 3'd3), WIDTH'(1));

        // address wrap
        b0 = q_beats.size(); a0 = q_addr.size();
        start_xfer(DEPTH - 2, 4);
        run_xfer(50, 0);
        chk("wrap_nissue", WIDTH'(q_addr.size() - a0), WIDTH'(4));
        if (q_addr.size() >= a0 + 4) begin
            chk("wrap_a0", WIDTH'(q_addr[a0]),     WIDTH'(1022));
            chk("wrap_a1", WIDTH'(q_addr[a0 + 1]), WIDTH'(1023));
            chk("wrap_a2", WIDTH'(q_addr[a0 + 2]), WIDTH'(0));
            chk("wrap_a3", WIDTH'(q_addr[a0 + 3]), WIDTH'(1));
        end
        check_beats(b0, DEPTH - 2, 4);

        // zero length
        b0 = q_beats.size(); a0 = q_addr.size(); d0 = n_done;
        start_xfer(5, 0);
        chk("zl_done",  WIDTH'(done), WIDTH'(1));
        chk("zl_busy",  WIDTH'(busy), '0);
        chk("zl_en",    WIDTH'(mem_en), '0);
        chk("zl_valid", WIDTH'(m_valid), '0);
        tick();
        chk("zl_done_off", WIDTH'(done), '0);
        chk("zl_busy2", WIDTH'(busy), '0);
        tick();
        chk("zl_nissue", WIDTH'(q_addr.size() - a0), '0);
        chk("zl_nbeats", WIDTH'(q_beats.size() - b0), '0);
        chk("zl_ndone",  WIDTH'(n_done - d0), WIDTH'(1));

        // start while busy is ignored
        b0 = q_beats.size(); a0 = q_addr.size(); d0 = n_done;
        start_xfer(16'h040, 6);
        start_xfer(16'h200, 3);
        run_xfer(50, 0);
        repeat (4) tick();
        check_beats(b0, 16'h040, 6);
        chk("sb_nissue", WIDTH'(q_addr.size() - a0), WIDTH'(6));
        chk("sb_ndone",  WIDTH'(n_done - d0), WIDTH'(1));

        // reset mid-transfer
        b0 = q_beats.size(); d0 = n_done;
        start_xfer(16'h080, 8);
        begin
            bit got3 = 0;
            for (int i = 0; i < 20; i++) begin
                if (q_beats.size() - b0 >= 3) begin got3 = 1; break; end
                tick();
            end
            chk("rm_3beats", WIDTH'(got3), WIDTH'(1));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_busy",  WIDTH'(busy), '0);
        chk("rm_done",  WIDTH'(done), '0);
        chk("rm_en",    WIDTH'(mem_en), '0);
        chk("rm_addr",  WIDTH'(mem_addr), '0);
        chk("rm_valid", WIDTH'(m_valid), '0);
        chk("rm_data",  m_data, '0);
        b1 = q_beats.size(); d1 = n_done;
        repeat (4) tick();
        chk("rm_stale", WIDTH'(q_beats.size() - b1), '0);
        chk("rm_nodone", WIDTH'(n_done - d1), '0);
        chk("rm_ndone_abort", WIDTH'(d1 - d0), '0);
        start_xfer(16'h300, 2);
        run_xfer(50, 0);
        check_beats(b1, 16'h300, 2);
        chk("rm_ndone_new", WIDTH'(n_done - d1), WIDTH'(1));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side client for the team's single-port block memory (1-cycle registered read latency, en/we/addr/din/dout port).
- On `start`, reads `len` consecutive words beginning at `base_addr` and presents them in order on a valid/ready output stream.
- Provides full throughput under continuous `m_ready` and loses no data under backpressure.
- Sits between the input/weight BRAMs and the GEMM core operand loaders.

Parameters:
- WIDTH, 128, memory/stream data width.
- DEPTH, 1024, memory depth in words.
- AW, 10, address width; equals clog2(DEPTH).
- LW, 11, transfer length width; maximum len = 2^LW-1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- base_addr  input  AW  first word address; latched on accepted start.
- len  input  LW  number of words to read; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the transfer is complete.
- mem_en  output  1  BRAM enable; one read per asserted cycle.
- mem_we  output  1  BRAM write enable; constant 0.
- mem_addr  output  AW  BRAM address.
- mem_dout  input  WIDTH  BRAM read data; valid the cycle after mem_en.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream ready.
- m_data  output  WIDTH  output beat data.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; the FIFO is flushed; any read in flight is discarded.
  - busy, done, mem_en, m_valid = 0; mem_addr and m_data = 0; mem_we is always 0.
  - Reset mid-transfer abandons it with no done pulse.
- FSM states:
  - IDLE: start=1 latches addr=base_addr and remain=len, then goes to READ. If len=0, go to FIN instead.
  - READ: issues reads. Leaves when remain reaches 0 after the final issue, going to DRAIN.
  - DRAIN: waits until inflight=0 and the FIFO is empty with the last beat accepted, then goes to FIN.
  - FIN: done=1 for exactly one cycle, then returns to IDLE.
- busy is 1 in READ/DRAIN/FIN-entry; precisely, busy=1 iff state is READ or DRAIN. busy drops in the same cycle done pulses.
- Start handling: start in any state other than IDLE is ignored and no error is raised.
- Read issue: in READ, mem_en=1 iff remain>0 and (fifo_count + inflight) < 3, where inflight = mem_en of the previous cycle.
- Each issue does mem_addr=addr, then addr+1 modulo DEPTH (wrap from DEPTH-1 to 0), and remain-1.
- mem_addr holds its value when mem_en=0.
- Capture: when inflight=1, mem_dout is written into a 4-entry FIFO at that edge.
- Output: m_valid = FIFO not empty; m_data = FIFO head (registered storage, no combinational path from mem_dout).
- Pop: a beat transfers when m_valid and m_ready are both 1.
- Push and pop in the same cycle are both honoured; count is unchanged.
- The credit rule bounds fifo_count at 3, so the FIFO cannot overflow; overflow is an assertion failure.
- m_valid, once high, stays high with m_data stable until the handshake.
- Latency for start accepted at edge T:
  - mem_en=1 with addr=base during cycle T+1.
  - Data is captured at the end of T+2; m_valid=1 in cycle T+3.
- Throughput: with m_ready held at 1, mem_en is asserted every cycle and one beat is output per cycle.
- Completion:
  - done pulses in the cycle after the handshake of beat len-1.
  - For len=0: done pulses in cycle T+1, with no mem_en and no m_valid.
- Ordering: beats leave in address order; each word is read exactly once.

Test Plan:
- Basic stream: rst then start with base=0x010, len=4, m_ready=1, memory[i]=i.
  - mem_en high in cycles T+1..T+4 with addr 0x010..0x013.
  - m_data 0x10..0x13 in cycles T+3..T+6; done at T+7; busy low at T+7.
- Backpressure: len=8, m_ready toggles 1,0,0,1,…
  - All 8 words are delivered in order with no duplicates.
  - fifo_count never exceeds 3.
  - m_data is stable while m_valid=1 and m_ready=0.
- Wrap: base=DEPTH-2, len=4.
  - Addresses issued are 1022, 1023, 0, 1 and data matches memory.
- Zero length: len=0.
  - No mem_en and no m_valid; done pulses at T+1; busy stays 0.
- Start while busy: assert start with base=0x200 during a len=6 transfer.
  - It is ignored; only the original 6 words appear and exactly one done pulse occurs.
- Reset mid-operation: rst after 3 beats, then a new start with len=2.
  - Outputs are 0 the cycle after reset, with no stale beat and no done for the aborted transfer.
  - The new transfer completes correctly.
